// File: rtl/reg_dump_reader_pkg.sv
// Shared widths, FSM state encoding and small helpers for the register dump reader.
package reg_dump_reader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    // Word counter must hold 1..NUM_REGS inclusive, hence one extra bit.
    localparam int CNT_W = $clog2(NUM_REGS) + 1;

    localparam logic [REG_ADDR_W-1:0] ADDR_ONE = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] ADDR_TWO = REG_ADDR_W'(2);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_TWO  = CNT_W'(2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EMIT0 = 3'd2,
        ST_EMIT1 = 3'd3,
        ST_DONE  = 3'd4
    } dump_state_t;

    // Number of words in an inclusive, wrapping address range (1..NUM_REGS).
    // The address subtraction wraps naturally in REG_ADDR_W bits.
    function automatic logic [CNT_W-1:0] word_count(
        input logic [REG_ADDR_W-1:0] first,
        input logic [REG_ADDR_W-1:0] last
    );
        logic [REG_ADDR_W-1:0] span;
        span = last - first;
        return {1'b0, span} + CNT_ONE;
    endfunction

endpackage

// File: rtl/reg_pair_buffer.sv
// Two-entry capture buffer holding one pair of register-file read results.
// Entry 0 is always valid after a load; entry 1 is kept valid only when the
// caller says a second word remains, so a trailing odd read is never emitted.
module reg_pair_buffer
    import reg_dump_reader_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              keep_second,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] entry0,
    output logic [DATA_W-1:0] entry1,
    output logic              entry0_valid,
    output logic              entry1_valid
);

    // Capture both read ports together; reset clears contents and flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            entry0       <= '0;
            entry1       <= '0;
            entry0_valid <= 1'b0;
            entry1_valid <= 1'b0;
        end else if (load) begin
            entry0       <= data0;
            entry1       <= data1;
            entry0_valid <= 1'b1;
            entry1_valid <= keep_second;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// Register dump reader: walks an inclusive, wrapping range of register
// addresses two at a time through a dual-read-port register file and emits
// (address, data) words over a valid/ready handshake, pulsing Done at the end.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [REG_ADDR_W-1:0] FirstReg,
    input  logic [REG_ADDR_W-1:0] LastReg,
    output logic [REG_ADDR_W-1:0] ReadRegister1,
    output logic [REG_ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0]     ReadData1,
    input  logic [DATA_W-1:0]     ReadData2,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [REG_ADDR_W-1:0] OutReg,
    output logic [DATA_W-1:0]     OutData,
    output logic                  Busy,
    output logic                  Done
);

    dump_state_t           state;
    logic [REG_ADDR_W-1:0] cur;
    logic [CNT_W-1:0]      remaining;

    logic                  buf_load;
    logic                  buf_keep_second;
    logic [DATA_W-1:0]     entry0;
    logic [DATA_W-1:0]     entry1;
    logic                  entry0_valid;
    logic                  entry1_valid;

    // The pair is captured on the edge that leaves FETCH; the second word is
    // kept only if at least two words are still owed.
    assign buf_load        = (state == ST_FETCH);
    assign buf_keep_second = (remaining >= CNT_TWO);

    reg_pair_buffer u_pair_buffer (
        .Clk          (Clk),
        .Reset        (Reset),
        .load         (buf_load),
        .keep_second  (buf_keep_second),
        .data0        (ReadData1),
        .data1        (ReadData2),
        .entry0       (entry0),
        .entry1       (entry1),
        .entry0_valid (entry0_valid),
        .entry1_valid (entry1_valid)
    );

    // Dump sequencing: capture range on Start, then fetch/emit pairs until done.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cur       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        cur       <= FirstReg;
                        remaining <= word_count(FirstReg, LastReg);
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_EMIT0;
                end
                ST_EMIT0: begin
                    if (OutReady) begin
                        state <= entry1_valid ? ST_EMIT1 : ST_DONE;
                    end
                end
                ST_EMIT1: begin
                    if (OutReady) begin
                        cur       <= cur + ADDR_TWO;
                        remaining <= remaining - CNT_TWO;
                        state     <= (remaining > CNT_TWO) ? ST_FETCH : ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore output decode from registered state, pointer and buffer; every
    // output is zero unless its state drives it, so reset zeroes them at once.
    always_comb begin
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        OutValid      = 1'b0;
        OutReg        = '0;
        OutData       = '0;
        Done          = 1'b0;
        Busy          = (state != ST_IDLE);
        case (state)
            ST_FETCH: begin
                ReadRegister1 = cur;
                ReadRegister2 = cur + ADDR_ONE;
            end
            ST_EMIT0: begin
                OutValid = entry0_valid;
                OutReg   = cur;
                OutData  = entry0;
            end
            ST_EMIT1: begin
                OutValid = entry1_valid;
                OutReg   = cur + ADDR_ONE;
                OutData  = entry1;
            end
            ST_DONE: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized self-checking bench for reg_dump_reader with a behavioural
// register file and a queue-based expected-word model.
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic                  Start;
    logic [REG_ADDR_W-1:0] FirstReg;
    logic [REG_ADDR_W-1:0] LastReg;
    logic [REG_ADDR_W-1:0] ReadRegister1;
    logic [REG_ADDR_W-1:0] ReadRegister2;
    logic [DATA_W-1:0]     ReadData1;
    logic [DATA_W-1:0]     ReadData2;
    logic                  OutValid;
    logic                  OutReady;
    logic [REG_ADDR_W-1:0] OutReg;
    logic [DATA_W-1:0]     OutData;
    logic                  Busy;
    logic                  Done;

    logic [DATA_W-1:0] regfile [NUM_REGS];

    assign ReadData1 = regfile[ReadRegister1];
    assign ReadData2 = regfile[ReadRegister2];

    always #5 Clk = ~Clk;

    reg_dump_reader dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .FirstReg      (FirstReg),
        .LastReg       (LastReg),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .OutReg        (OutReg),
        .OutData       (OutData),
        .Busy          (Busy),
        .Done          (Done)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int          exp_reg[$];
    logic [31:0] exp_data[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        tests_run++;
        if (got !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
        end
    endtask

    // Cycle (counted from the Start edge) in which Done is seen, OutReady high.
    function automatic int done_cycle(input int n);
        int pairs;
        pairs = (n + 1) / 2;
        return (n % 2 == 0) ? 3 * pairs + 1 : 3 * pairs;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(OutValid), 0);
        check({tag, "_reg"}, 32'(OutReg), 0);
        check({tag, "_data"}, OutData, 0);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_done"}, 32'(Done), 0);
        check({tag, "_rr"}, 32'({ReadRegister1, ReadRegister2}), 0);
    endtask

    // mode 0: ready high; 1: random ready; 2: stall 5 cycles at reg 10 plus stray Start.
    // abort_after >= 0: assert Reset once that many words have transferred.
    task automatic run_dump(input int first, input int last, input int mode,
                            input int abort_after, input int want_done_at);
        int          n;
        int          cycle;
        int          sent;
        int          stall;
        bit          done_seen;
        bit          prev_hold;
        logic [4:0]  hold_reg;
        logic [31:0] hold_data;

        exp_reg.delete();
        exp_data.delete();
        n = ((last - first) & 31) + 1;
        for (int i = 0; i < n; i++) begin
            exp_reg.push_back((first + i) & 31);
            exp_data.push_back(regfile[(first + i) & 31]);
        end

        sent = 0;
        stall = 0;
        done_seen = 0;
        prev_hold = 0;
        hold_reg = '0;
        hold_data = '0;

        @(negedge Clk);
        FirstReg = 5'(first);
        LastReg  = 5'(last);
        Start    = 1'b1;
        OutReady = 1'b1;
        @(negedge Clk);
        Start    = 1'b0;
        FirstReg = 5'($urandom_range(0, 31));
        LastReg  = 5'($urandom_range(0, 31));
        cycle = 1;
        check("start_busy", 32'(Busy), 1);
        check("start_no_valid", 32'(OutValid), 0);

        while (cycle < 300 && !done_seen) begin
            if (abort_after >= 0 && sent == abort_after) begin
                Reset = 1'b1;
                #1;
                check_all_zero("abort");
                return;
            end

            case (mode)
                0: OutReady = 1'b1;
                1: OutReady = 1'($urandom_range(0, 1));
                default: begin
                    if (OutValid && OutReg == 5'd10 && stall < 5) begin
                        OutReady = 1'b0;
                        stall++;
                        Start = (stall == 3);
                        if (stall == 3) begin
                            FirstReg = 5'd0;
                            LastReg  = 5'd3;
                        end
                    end else begin
                        OutReady = 1'b1;
                        Start    = 1'b0;
                    end
                end
            endcase

            if (prev_hold) begin
                check("hold_valid", 32'(OutValid), 1);
                check("hold_reg", 32'(OutReg), 32'(hold_reg));
                check("hold_data", OutData, hold_data);
            end

            if (Done) begin
                done_seen = 1;
                check("done_all_sent", exp_reg.size(), 0);
                check("done_no_valid", 32'(OutValid), 0);
                if (want_done_at > 0) check("done_latency", cycle, want_done_at);
            end else if (OutValid) begin
                check("emit_rr_zero", 32'({ReadRegister1, ReadRegister2}), 0);
                if (exp_reg.size() == 0) begin
                    check("extra_word", 32'(OutReg), 32'hFFFF_FFFF);
                end else begin
                    check("out_reg", 32'(OutReg), exp_reg[0]);
                    check("out_data", OutData, exp_data[0]);
                    if (OutReady) begin
                        void'(exp_reg.pop_front());
                        void'(exp_data.pop_front());
                        sent++;
                    end
                end
            end else begin
                check("fetch_busy", 32'(Busy), 1);
                if (exp_reg.size() > 0) begin
                    check("fetch_rr1", 32'(ReadRegister1), exp_reg[0]);
                    check("fetch_rr2", 32'(ReadRegister2), (exp_reg[0] + 1) & 31);
                end
            end

            prev_hold = OutValid && !OutReady;
            hold_reg  = OutReg;
            hold_data = OutData;

            @(negedge Clk);
            cycle++;
        end

        Start = 1'b0;
        if (!done_seen) check("done_timeout", 0, 1);
        check("post_done_idle", 32'(Busy), 0);
        check("post_done_pulse", 32'(Done), 0);
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regfile[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        regfile[8]  = 32'h0ECE_274A;
        regfile[9]  = 32'h0000_2222;
        regfile[10] = 32'h0000_2525;
        regfile[24] = 32'hF1E2_FFFF;
        regfile[25] = 32'h2F1E_FFFF;
        regfile[31] = 32'd1000;

        Reset    = 1'b1;
        Start    = 1'b0;
        OutReady = 1'b0;
        FirstReg = '0;
        LastReg  = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Full range, first/last words come from the fixed preload.
        run_dump(8, 25, 0, -1, 28);
        // Single word: the companion read of R10 must not appear.
        run_dump(9, 9, 0, -1, 3);
        // Wrap-around through R31 -> R0.
        run_dump(30, 1, 0, -1, done_cycle(4));
        // Backpressure on (10, 0x2525) with an ignored Start in the middle.
        run_dump(8, 25, 2, -1, 33);

        // Reset after three words: everything clears, no Done follows.
        run_dump(8, 25, 0, 3, 0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("after_abort_done", 32'(Done), 0);
            check("after_abort_busy", 32'(Busy), 0);
            @(negedge Clk);
        end
        run_dump(8, 25, 0, -1, 28);

        // Random ranges with random and steady handshakes.
        for (int t = 0; t < 6; t++) begin
            run_dump($urandom_range(0, 31), $urandom_range(0, 31), 1, -1, 0);
        end
        for (int t = 0; t < 3; t++) begin
            int f;
            int l;
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            run_dump(f, l, 0, -1, done_cycle(((l - f) & 31) + 1));
        end
        run_dump(5, 4, 1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
